btn_binary_counter: RTL
=======================

# btn_binary_counter

Button-driven 4-bit binary counter: the stage that produces the `i_binary` nibble for the 7-segment decoder. Three raw push-button inputs (up, down, clear) are synchronised and debounced, and their press edges drive a wrap-around counter. The counter value goes straight to the decoder's `i_binary` input. Single clock domain; all outputs registered.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive samples a synchronised input must hold a new level before it is accepted (10 ms at 25 MHz); legal range 1 to 2^20-1.
- `COUNT_MAX`, default 9: terminal count; legal range 1..15.
- `i_Clk`  in  1: system clock; all logic on rising edge.
- `i_Rst_n`  in  1: reset, asynchronous assert, active-low.
- `i_Btn_Up`  in  1: raw up button, active-high, asynchronous to `i_Clk`.
- `i_Btn_Down`  in  1: raw down button, active-high, asynchronous.
- `i_Btn_Clear`  in  1: raw clear button, active-high, asynchronous.
- `o_Binary`  out  4: current count; drives the decoder's `i_binary`.
- `o_Tick`  out  1: one-cycle pulse in the cycle `o_Binary` takes a new value.
- `o_Wrap`  out  1: one-cycle pulse coincident with `o_Tick` when the change crossed the 0/`COUNT_MAX` boundary.

## Operation
- Per button: 2-flop synchroniser, then debounce filter holding a stable level plus a sample counter (20 bits).
- Filter behaviour:
  - Each cycle the synchronised sample equals the stable level: counter clears to 0.
  - Sample differs: counter increments.
  - Counter reaches `DEBOUNCE_CYCLES`: stable level toggles and counter clears.
  - Any single agreeing sample (bounce) restarts the count.
- A press event is a 0→1 transition of a stable level. Release events are ignored.
- Counter update, evaluated on each clock in priority order:
  1. Clear press: `o_Binary` ← 0. `o_Tick`=1 only if the value was non-zero. `o_Wrap`=0.
  2. Up and down press in the same cycle: no change, no pulses.
  3. Up press: if `o_Binary`==`COUNT_MAX` then 0 with `o_Wrap`=1; else +1. `o_Tick`=1.
  4. Down press: if `o_Binary`==0 then `COUNT_MAX` with `o_Wrap`=1; else −1. `o_Tick`=1.
- `o_Binary` never exceeds `COUNT_MAX`. Arithmetic is 4-bit unsigned with explicit compare; the counter never relies on natural 4-bit overflow.
- Holding a button produces exactly one event; there is no auto-repeat.
- Reset values: `o_Binary`=0, `o_Tick`=0, `o_Wrap`=0; synchronisers, stable levels and debounce counters all 0.
- A button still held when reset deasserts is treated as a new press: one event after the normal latency.
- Reset asserted mid-debounce discards the partial count.

## Timing
- Raw input changes and is stable before edge 1.
- Synchroniser output is valid at edge 2.
- Stable level toggles at edge 2+`DEBOUNCE_CYCLES`.
- `o_Binary`, `o_Tick` and `o_Wrap` update at edge 3+`DEBOUNCE_CYCLES`.
- `o_Tick`/`o_Wrap` are high for exactly one cycle.
- Minimum spacing between two events from the same button is 2×`DEBOUNCE_CYCLES` cycles (press, release, press). Events from different buttons may land in any cycle.

## Structure
- Shared header `counter_defs.vh`:
  - `COUNT_W` = 4
  - `DB_CNT_W` = 20
  - default `DEBOUNCE_CYCLES` and `COUNT_MAX`
- Sub-module `switch_debounce`:
  - contents: synchroniser, filter and registered press-edge detect
  - ports: `i_Clk`, `i_Rst_n`, `i_Switch`, `o_Level`, `o_Press`
  - instantiated three times
- Top: priority logic plus the count register.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `COUNT_MAX`=9.
- Reset held, buttons idle → `o_Binary`=0, `o_Tick`=0, `o_Wrap`=0; then 10 up presses → sequence 1..9, 0. `o_Wrap` pulses only on the 9→0 step. Each update occurs at edge 7 after the press.
- Up bouncing 1,0,1,0, then steady 1 for 4 cycles → exactly one increment, timed from the start of the steady run.
- From 0, one down press → `o_Binary`=9 with `o_Wrap`=1; a second down press → 8 with `o_Wrap`=0.
- Up and down pressed in the same cycle → value unchanged, no `o_Tick`. Clear pressed with up at value 5 → 0 with `o_Tick`=1.
- Up held for 100 cycles → a single increment. Clear pressed at value 0 → no `o_Tick`.
- Reset asserted at count 2 with up mid-debounce → outputs 0 immediately. Up still held after release → `o_Binary`=1 at edge 7 after deassertion.

Source files
------------

// File: rtl/btn_binary_counter_pkg.sv
// Shared widths, defaults and command decode for the button-driven 4-bit counter.
// Button indices fix the packing order of the raw button vector in the top level.
package btn_binary_counter_pkg;

   localparam int COUNT_W             = 4;
   localparam int DB_CNT_W            = 20;
   localparam int DEBOUNCE_CYCLES_DEF = 250000;
   localparam int COUNT_MAX_DEF       = 9;

   localparam int NUM_BTNS  = 3;
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_CLEAR = 2;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_CLEAR = 2'd1,
      CMD_UP    = 2'd2,
      CMD_DOWN  = 2'd3
   } cmd_e;

   // Clear dominates; simultaneous up and down cancel each other out.
   function automatic cmd_e decode_cmd(input logic clear, input logic up, input logic down);
      if (clear)       return CMD_CLEAR;
      if (up && down)  return CMD_NONE;
      if (up)          return CMD_UP;
      if (down)        return CMD_DOWN;
      return CMD_NONE;
   endfunction

endpackage

// File: rtl/btn_binary_counter_switch_debounce.sv
// One push button: 2-flop synchroniser, consecutive-sample debounce filter and a
// registered press (0->1 of the filtered level) pulse.
module switch_debounce
   import btn_binary_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   input  logic i_Switch,
   output logic o_Level,
   output logic o_Press
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                meta_q;
   logic                sync_q;
   logic                level_q;
   logic                level_d;
   logic [DB_CNT_W-1:0] cnt_q;
   logic [DB_CNT_W-1:0] cnt_d;
   logic                press_q;
   logic                press_d;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_Switch;
         sync_q <= meta_q;
      end
   end

   // The count only survives while every sample disagrees with the stable level;
   // the DEBOUNCE_CYCLES-th disagreeing sample flips the level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            press_d = ~level_q;
         end else begin
            cnt_d = cnt_q + DB_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign o_Level = level_q;
   assign o_Press = press_q;

endmodule

// File: rtl/btn_binary_counter.sv
// Debounced up/down/clear buttons driving a wrap-around 0..COUNT_MAX counter that
// feeds the 7-segment decoder's i_binary nibble.
module btn_binary_counter
   import btn_binary_counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int COUNT_MAX       = COUNT_MAX_DEF
) (
   input  logic               i_Clk,
   input  logic               i_Rst_n,
   input  logic               i_Btn_Up,
   input  logic               i_Btn_Down,
   input  logic               i_Btn_Clear,
   output logic [COUNT_W-1:0] o_Binary,
   output logic               o_Tick,
   output logic               o_Wrap
);

   localparam logic [COUNT_W-1:0] COUNT_MAX_V = COUNT_W'(COUNT_MAX);

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] btn_press;
   logic [NUM_BTNS-1:0] level_unused;

   logic [COUNT_W-1:0] bin_q;
   logic [COUNT_W-1:0] bin_d;
   logic               tick_q;
   logic               tick_d;
   logic               wrap_q;
   logic               wrap_d;
   cmd_e               cmd;

   assign btn_raw[BTN_UP]    = i_Btn_Up;
   assign btn_raw[BTN_DOWN]  = i_Btn_Down;
   assign btn_raw[BTN_CLEAR] = i_Btn_Clear;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
         switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Switch(btn_raw[gi]),
            .o_Level (level_unused[gi]),
            .o_Press (btn_press[gi])
         );
      end
   endgenerate

   // Wrap is detected by explicit compare so the range 0..COUNT_MAX holds for any COUNT_MAX.
   always_comb begin
      cmd    = decode_cmd(btn_press[BTN_CLEAR], btn_press[BTN_UP], btn_press[BTN_DOWN]);
      bin_d  = bin_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      unique case (cmd)
         CMD_CLEAR: begin
            bin_d  = '0;
            tick_d = (bin_q != '0);
         end
         CMD_UP: begin
            tick_d = 1'b1;
            if (bin_q == COUNT_MAX_V) begin
               bin_d  = '0;
               wrap_d = 1'b1;
            end else begin
               bin_d = bin_q + COUNT_W'(1);
            end
         end
         CMD_DOWN: begin
            tick_d = 1'b1;
            if (bin_q == '0) begin
               bin_d  = COUNT_MAX_V;
               wrap_d = 1'b1;
            end else begin
               bin_d = bin_q - COUNT_W'(1);
            end
         end
         default: begin
            bin_d = bin_q;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         bin_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign o_Binary = bin_q;
   assign o_Tick   = tick_q;
   assign o_Wrap   = wrap_q;

endmodule
